dot_operand_sequencer: RTL and testbench

//  Upstream feeder for the serial dot-product engine, which has no input valid and samples din on every edge.
//  - Accepts operand-vector pairs (A,B) as wide words over a valid/ready handshake.
//  - Buffers the pairs, then streams bytes to the engine in the order A0..A(N-1), B0..B(N-1).
//  - Owns the engine's reset (dp_resetn) to keep frames aligned, because the engine cannot stall.
//  - Flags the one cycle in which the engine's result is valid.

---
 rtl/dot_pkg.sv | 15 +
 rtl/dot_operand_sequencer_pair_fifo.sv | 47 ++++
 rtl/dot_operand_sequencer.sv | 117 +++++++++++
 tb/tb_dot_operand_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_pkg.sv
// Shared constants and types for the dot-product operand sequencer.
package dot_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int VEC_LENGTH = 3;
  localparam int FRAME_LEN  = 2*VEC_LENGTH;
  localparam int RES_WIDTH  = 2*DATA_WIDTH + $clog2(VEC_LENGTH);
  localparam int IDX_W      = $clog2(FRAME_LEN);

  typedef enum logic {IDLE, STREAM} seq_state_t;
  typedef logic [VEC_LENGTH*DATA_WIDTH-1:0] vec_t;
  typedef struct packed {
    vec_t b;
    vec_t a;
  } pair_t;
endpackage

// File: rtl/dot_operand_sequencer_pair_fifo.sv
// Synchronous FIFO of operand pairs; head is always visible, pop advances it.
module pair_fifo
  import dot_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int OCC_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [VEC_LENGTH*DATA_WIDTH-1:0] push_a,
  input  logic [VEC_LENGTH*DATA_WIDTH-1:0] push_b,
  input  logic             pop,
  output logic [VEC_LENGTH*DATA_WIDTH-1:0] head_a,
  output logic [VEC_LENGTH*DATA_WIDTH-1:0] head_b,
  output logic [OCC_W-1:0] occupancy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pair_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  assign head_a = mem[rd_ptr].a;
  assign head_b = mem[rd_ptr].b;

  // Storage write; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{b: push_b, a: push_a};
  end

  // Pointer and occupancy bookkeeping; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      occupancy <= occupancy + OCC_W'(push) - OCC_W'(pop);
    end
  end
endmodule

// File: rtl/dot_operand_sequencer.sv
// Buffers (A,B) operand pairs and streams them byte-serially to a dot-product
// engine that cannot stall, owning the engine reset to keep frames aligned.
module dot_operand_sequencer
  import dot_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [VEC_LENGTH*DATA_WIDTH-1:0] s_a,
  input  logic [VEC_LENGTH*DATA_WIDTH-1:0] s_b,
  output logic [DATA_WIDTH-1:0]            dp_din,
  output logic                             dp_resetn,
  output logic                             res_valid,
  output logic                             busy,
  output logic [15:0]                      frames
);
  localparam int OCC_W = $clog2(FIFO_DEPTH+1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN-1);

  seq_state_t                    state, state_n;
  logic [IDX_W-1:0]              idx, idx_n;
  logic [FRAME_LEN*DATA_WIDTH-1:0] shreg, shreg_n;
  logic [DATA_WIDTH-1:0]         dp_din_n;
  logic                          dp_resetn_n, res_valid_n, s_ready_n, busy_n;
  logic [15:0]                   frames_n;
  logic                          push, load, last_byte, fifo_ne;
  logic [VEC_LENGTH*DATA_WIDTH-1:0] head_a, head_b;
  logic [OCC_W-1:0]              occ, occ_n;

  assign push      = s_valid && s_ready;
  assign fifo_ne   = (occ != '0);
  assign last_byte = (state == STREAM) && (idx == LAST);

  pair_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_a    (s_a),
    .push_b    (s_b),
    .pop       (load),
    .head_a    (head_a),
    .head_b    (head_b),
    .occupancy (occ)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // Next state: start a frame whenever a pair is waiting; chain frames with no gap.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    case (state)
      IDLE:   if (fifo_ne) begin load = 1'b1; state_n = STREAM; end
      STREAM: if (last_byte) begin
                if (fifo_ne) load = 1'b1;
                else         state_n = IDLE;
              end
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    occ_n       = occ + OCC_W'(push) - OCC_W'(load);
    s_ready_n   = (occ_n < OCC_W'(FIFO_DEPTH));
    busy_n      = (state_n == STREAM) || (occ_n != '0);
    dp_resetn_n = (state_n == STREAM);
    res_valid_n = last_byte;
    frames_n    = frames + 16'(last_byte);
    dp_din_n    = dp_din;
    idx_n       = idx;
    shreg_n     = shreg;
    if (load) begin
      // A0 goes straight to the bus; the rest queue up LSB-first behind it.
      dp_din_n = head_a[DATA_WIDTH-1:0];
      shreg_n  = {head_b, head_a} >> DATA_WIDTH;
      idx_n    = '0;
    end else if (state_n == IDLE) begin
      dp_din_n = '0;
      idx_n    = '0;
    end else begin
      dp_din_n = shreg[DATA_WIDTH-1:0];
      shreg_n  = shreg >> DATA_WIDTH;
      idx_n    = idx + IDX_W'(1);
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      idx       <= '0;
      shreg     <= '0;
      dp_din    <= '0;
      dp_resetn <= 1'b0;
      res_valid <= 1'b0;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      frames    <= '0;
    end else begin
      idx       <= idx_n;
      shreg     <= shreg_n;
      dp_din    <= dp_din_n;
      dp_resetn <= dp_resetn_n;
      res_valid <= res_valid_n;
      s_ready   <= s_ready_n;
      busy      <= busy_n;
      if (last_byte) frames <= frames_n;
    end
  end
endmodule

// File: tb/tb_dot_operand_sequencer.sv
// Directed bench: sequencer driving a behavioural serial dot-product engine.
module tb_dot_operand_sequencer;
  import dot_pkg::*;

  logic        clk = 1'b0, resetn = 1'b0, s_valid = 1'b0;
  logic        s_ready, dp_resetn, res_valid, busy;
  vec_t        s_a = '0, s_b = '0;
  logic [7:0]  dp_din;
  logic [15:0] frames;
  int total = 0, bad = 0, cyc = 0, stalls = 0, acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dot_operand_sequencer #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b), .dp_din(dp_din), .dp_resetn(dp_resetn),
    .res_valid(res_valid), .busy(busy), .frames(frames)
  );

  // Engine: samples din every edge, stores A, accumulates A*B, flags run after 2N bytes.
  logic [7:0]  ea [3];
  logic [2:0]  ecnt = '0;
  logic [17:0] eacc = '0, dout = '0;
  logic        run = 1'b0;
  always @(posedge clk) begin
    if (!dp_resetn) begin
      ecnt <= '0; eacc <= '0; run <= 1'b0; dout <= '0;
    end else if (ecnt < 3'd3) begin
      ea[ecnt[1:0]] <= dp_din; run <= 1'b0; ecnt <= ecnt + 3'd1;
    end else if (ecnt == 3'd5) begin
      dout <= eacc + 18'(ea[2]) * 18'(dp_din); run <= 1'b1; ecnt <= '0; eacc <= '0;
    end else begin
      eacc <= eacc + 18'(ea[2'(ecnt - 3'd3)]) * 18'(dp_din); run <= 1'b0; ecnt <= ecnt + 3'd1;
    end
  end

  // Logs of bus bytes and result pulses, sampled mid-cycle.
  logic [7:0]  byte_q[$];
  int          byte_cyc_q[$];
  logic [17:0] res_q[$];
  logic        res_run_q[$], res_rst_q[$];
  int          res_cyc_q[$];
  always @(negedge clk) begin
    if (dp_resetn === 1'b1) begin byte_q.push_back(dp_din); byte_cyc_q.push_back(cyc); end
    if (res_valid === 1'b1) begin
      res_q.push_back(dout); res_run_q.push_back(run);
      res_cyc_q.push_back(cyc); res_rst_q.push_back(dp_resetn);
    end
  end

  function automatic vec_t pk(input int e0, input int e1, input int e2);
    return {8'(e2), 8'(e1), 8'(e0)};
  endfunction

  task automatic clear_logs();
    byte_q.delete(); byte_cyc_q.delete();
    res_q.delete(); res_run_q.delete(); res_rst_q.delete(); res_cyc_q.delete();
  endtask

  // Offer a pair (call at negedge); returns at the negedge after acceptance.
  task automatic push(input vec_t a, input vec_t b);
    int t;
    t = 0;
    s_valid = 1'b1; s_a = a; s_b = b;
    while (!s_ready && t < 100) begin @(negedge clk); t++; stalls++; end
    total++;
    if (!s_ready) begin bad++; $display("FAIL push_timeout s_ready=%0b want 1", s_ready); end
    @(negedge clk);
    acc_cyc = cyc;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (busy && t < 300);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_timeout busy=%0b want 0", busy); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    total += 6;
    if (s_ready   !== 1'b0) begin bad++; $display("FAIL rst_s_ready got %0b want 0", s_ready); end
    if (dp_din    !== 8'd0) begin bad++; $display("FAIL rst_dp_din got %0h want 0", dp_din); end
    if (dp_resetn !== 1'b0) begin bad++; $display("FAIL rst_dp_resetn got %0b want 0", dp_resetn); end
    if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got %0b want 0", res_valid); end
    if (busy      !== 1'b0) begin bad++; $display("FAIL rst_busy got %0b want 0", busy); end
    if (frames    !== 16'd0) begin bad++; $display("FAIL rst_frames got %0d want 0", frames); end
    resetn = 1'b1;
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_rise got %0b want 1", s_ready); end
  endtask

  task automatic test_single();
    clear_logs();
    push(pk(1,2,3), pk(4,5,6));
    s_valid = 1'b0;
    wait_idle();
    total++;
    if (byte_q.size() != 6) begin bad++; $display("FAIL t1_nbytes got %0d want 6", byte_q.size()); end
    else for (int i = 0; i < 6; i++) begin
      total++;
      if (byte_q[i] !== 8'(i+1) || byte_cyc_q[i] != acc_cyc + 1 + i) begin
        bad++; $display("FAIL t1_byte%0d got %0d@%0d want %0d@%0d", i, byte_q[i], byte_cyc_q[i], i+1, acc_cyc+1+i);
      end
    end
    total++;
    if (res_q.size() != 1) begin bad++; $display("FAIL t1_nres got %0d want 1", res_q.size()); end
    else begin
      total += 4;
      if (res_q[0] !== 18'd32) begin bad++; $display("FAIL t1_dout got %0d want 32", res_q[0]); end
      if (res_run_q[0] !== 1'b1) begin bad++; $display("FAIL t1_run got %0b want 1", res_run_q[0]); end
      if (res_cyc_q[0] != acc_cyc + 7) begin bad++; $display("FAIL t1_res_cyc got %0d want %0d", res_cyc_q[0], acc_cyc+7); end
      if (res_rst_q[0] !== 1'b0) begin bad++; $display("FAIL t1_dp_resetn_drop got %0b want 0", res_rst_q[0]); end
    end
    total++;
    if (frames !== 16'd1) begin bad++; $display("FAIL t1_frames got %0d want 1", frames); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [12];
    exp = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd1, 8'd0, 8'd7, 8'd9, 8'd7};
    clear_logs();
    push(pk(255,255,255), pk(255,255,255));
    push(pk(0,1,0), pk(7,9,7));
    s_valid = 1'b0;
    wait_idle();
    total++;
    if (byte_q.size() != 12) begin bad++; $display("FAIL t2_nbytes got %0d want 12", byte_q.size()); end
    else for (int i = 0; i < 12; i++) begin
      total++;
      if (byte_q[i] !== exp[i] || byte_cyc_q[i] != byte_cyc_q[0] + i) begin
        bad++; $display("FAIL t2_byte%0d got %0d@%0d want %0d@%0d", i, byte_q[i], byte_cyc_q[i], exp[i], byte_cyc_q[0]+i);
      end
    end
    total++;
    if (res_q.size() != 2) begin bad++; $display("FAIL t2_nres got %0d want 2", res_q.size()); end
    else begin
      total += 5;
      if (res_q[0] !== 18'd195075) begin bad++; $display("FAIL t2_dout0 got %0d want 195075", res_q[0]); end
      if (res_q[1] !== 18'd9) begin bad++; $display("FAIL t2_dout1 got %0d want 9", res_q[1]); end
      if (res_cyc_q[1] - res_cyc_q[0] != 6) begin bad++; $display("FAIL t2_spacing got %0d want 6", res_cyc_q[1]-res_cyc_q[0]); end
      if (res_rst_q[0] !== 1'b1) begin bad++; $display("FAIL t2_no_gap got %0b want 1", res_rst_q[0]); end
      if (res_run_q[1] !== 1'b1) begin bad++; $display("FAIL t2_run got %0b want 1", res_run_q[1]); end
    end
    total++;
    if (frames !== 16'd3) begin bad++; $display("FAIL t2_frames got %0d want 3", frames); end
  endtask

  task automatic test_backpressure();
    logic [17:0] exp [4];
    exp = '{18'd6, 18'd20, 18'd15, 18'd60};
    clear_logs();
    stalls = 0;
    push(pk(1,1,1), pk(1,2,3));
    push(pk(2,0,0), pk(10,0,0));
    push(pk(0,0,3), pk(5,5,5));
    push(pk(10,20,30), pk(1,1,1));
    s_valid = 1'b0;
    wait_idle();
    total += 2;
    if (stalls == 0) begin bad++; $display("FAIL t3_stall got %0d stall cycles want >0", stalls); end
    if (byte_q.size() != 24) begin bad++; $display("FAIL t3_nbytes got %0d want 24", byte_q.size()); end
    total++;
    if (res_q.size() != 4) begin bad++; $display("FAIL t3_nres got %0d want 4", res_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      total++;
      if (res_q[i] !== exp[i]) begin bad++; $display("FAIL t3_dout%0d got %0d want %0d", i, res_q[i], exp[i]); end
    end
    total++;
    if (frames !== 16'd7) begin bad++; $display("FAIL t3_frames got %0d want 7", frames); end
  endtask

  task automatic test_gap();
    clear_logs();
    push(pk(3,0,0), pk(3,0,0));
    s_valid = 1'b0;
    wait_idle();
    total++;
    if (res_q.size() != 1 || res_q[0] !== 18'd9) begin bad++; $display("FAIL t4_first got n=%0d want one result of 9", res_q.size()); end
    clear_logs();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (dp_resetn !== 1'b0) begin bad++; $display("FAIL t4_gap_rst cycle %0d got %0b want 0", i, dp_resetn); end
    end
    push(pk(100,200,255), pk(255,255,255));
    s_valid = 1'b0;
    wait_idle();
    total += 2;
    if (byte_q.size() == 0 || byte_q[0] !== 8'd100 || byte_cyc_q[0] != acc_cyc + 1) begin
      bad++; $display("FAIL t4_first_byte got n=%0d want 100 at cycle %0d", byte_q.size(), acc_cyc+1);
    end
    if (res_q.size() != 1 || res_q[0] !== 18'd141525) begin bad++; $display("FAIL t4_dout got n=%0d want one result of 141525", res_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int t;
    t = 0;
    clear_logs();
    push(pk(9,9,9), pk(9,9,9));
    s_valid = 1'b0;
    while (byte_q.size() < 3 && t < 50) begin @(negedge clk); t++; end
    total++;
    if (byte_q.size() < 3) begin bad++; $display("FAIL t5_start got %0d bytes want 3", byte_q.size()); end
    resetn = 1'b0;
    @(negedge clk);
    total += 6;
    if (s_ready   !== 1'b0) begin bad++; $display("FAIL t5_s_ready got %0b want 0", s_ready); end
    if (dp_din    !== 8'd0) begin bad++; $display("FAIL t5_dp_din got %0h want 0", dp_din); end
    if (dp_resetn !== 1'b0) begin bad++; $display("FAIL t5_dp_resetn got %0b want 0", dp_resetn); end
    if (res_valid !== 1'b0) begin bad++; $display("FAIL t5_res_valid got %0b want 0", res_valid); end
    if (busy      !== 1'b0) begin bad++; $display("FAIL t5_busy got %0b want 0", busy); end
    if (frames    !== 16'd0) begin bad++; $display("FAIL t5_frames got %0d want 0", frames); end
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (res_q.size() != 0) begin bad++; $display("FAIL t5_dropped got %0d results want 0", res_q.size()); end
    clear_logs();
    push(pk(1,2,3), pk(1,1,1));
    s_valid = 1'b0;
    wait_idle();
    total += 2;
    if (res_q.size() != 1 || res_q[0] !== 18'd6) begin bad++; $display("FAIL t5_after got n=%0d want one result of 6", res_q.size()); end
    if (frames !== 16'd1) begin bad++; $display("FAIL t5_frames_after got %0d want 1", frames); end
  endtask

  task automatic test_wrap();
    clear_logs();
    force dut.frames = 16'hFFFF;
    @(negedge clk);
    release dut.frames;
    @(negedge clk);
    total++;
    if (frames !== 16'hFFFF) begin bad++; $display("FAIL t6_preload got %0h want ffff", frames); end
    push(pk(1,0,0), pk(1,0,0));
    s_valid = 1'b0;
    wait_idle();
    total += 2;
    if (frames !== 16'd0) begin bad++; $display("FAIL t6_wrap got %0h want 0", frames); end
    if (res_q.size() != 1 || res_q[0] !== 18'd1) begin bad++; $display("FAIL t6_dout got n=%0d want one result of 1", res_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_gap();
    test_reset_mid_frame();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule
